// File: rtl/expu_accumulator.sv
// Softmax-denominator accumulator: converts a beat of exponential-unit float results to
// unsigned fixed point, sums the lanes, and accumulates beats into one saturating sum per vector.

package fpnew_pkg;
    typedef enum logic [2:0] {FP32, FP64, FP16, FP8, FP16ALT} fp_format_e;

    typedef struct packed {
        int unsigned exp_bits;
        int unsigned man_bits;
    } fp_encoding_t;

    localparam int unsigned NUM_FP_FORMATS = 5;
    localparam fp_encoding_t [0:NUM_FP_FORMATS-1] FP_ENCODINGS = '{
        '{8, 23}, '{11, 52}, '{5, 10}, '{5, 2}, '{8, 7}
    };

    function automatic int unsigned fp_width(input fp_format_e fmt);
        return FP_ENCODINGS[fmt].exp_bits + FP_ENCODINGS[fmt].man_bits + 1;
    endfunction

    function automatic int unsigned exp_bits(input fp_format_e fmt);
        return FP_ENCODINGS[fmt].exp_bits;
    endfunction

    function automatic int unsigned man_bits(input fp_format_e fmt);
        return FP_ENCODINGS[fmt].man_bits;
    endfunction
endpackage

module expu_accumulator #(
    parameter fpnew_pkg::fp_format_e FPFORMAT  = fpnew_pkg::FP16ALT,
    parameter int                    N_ROWS    = 8,
    parameter int                    ACC_WIDTH = 32,
    parameter int                    ACC_FRAC  = 16,
    localparam int                   WIDTH     = int'(fpnew_pkg::fp_width(FPFORMAT))
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic                      clear_i,
    input  logic                      enable_i,
    input  logic                      valid_i,
    output logic                      ready_o,
    input  logic [N_ROWS-1:0]         strb_i,
    input  logic [N_ROWS*WIDTH-1:0]   op_i,
    input  logic                      last_i,
    output logic [ACC_WIDTH-1:0]      sum_o,
    output logic                      overflow_o,
    output logic                      valid_o,
    input  logic                      ready_i
);

    localparam int EXP_BITS  = int'(fpnew_pkg::exp_bits(FPFORMAT));
    localparam int MANT_BITS = int'(fpnew_pkg::man_bits(FPFORMAT));
    localparam int BIAS      = 2**(EXP_BITS-1) - 1;
    localparam int INT_BITS  = ACC_WIDTH - ACC_FRAC;
    localparam int SUM_WIDTH = ACC_WIDTH + $clog2(N_ROWS);
    localparam logic [ACC_WIDTH-1:0] ACC_MAX = '1;

    // Returns {saturated, value}; any normal value at or above 2^INT_BITS saturates.
    function automatic logic [ACC_WIDTH:0] convert_lane(input logic [WIDTH-1:0] x);
        logic [EXP_BITS-1:0]  e;
        logic [ACC_WIDTH-1:0] sig;
        int                   unb;
        int                   k;
        e   = x[WIDTH-2 -: EXP_BITS];
        sig = ACC_WIDTH'({1'b1, x[MANT_BITS-1:0]});
        unb = int'(e) - BIAS;
        k   = unb - MANT_BITS + ACC_FRAC;
        if (x[WIDTH-1] || e == '0)
            convert_lane = '0;
        else if (e == '1 || unb >= INT_BITS)
            convert_lane = {1'b1, ACC_MAX};
        else if (k >= 0)
            convert_lane = {1'b0, sig << k};
        else
            convert_lane = {1'b0, sig >> (-k)};
    endfunction

    logic                 s1_valid_q, s1_valid_d;
    logic                 s1_last_q,  s1_last_d;
    logic                 s1_sat_q,   s1_sat_d;
    logic [ACC_WIDTH-1:0] s1_sum_q,   s1_sum_d;
    logic [ACC_WIDTH-1:0] acc_q,      acc_d;
    logic                 sticky_q,   sticky_d;
    logic [ACC_WIDTH-1:0] sum_q,      sum_d;
    logic                 ovf_q,      ovf_d;
    logic                 valid_q,    valid_d;

    logic [ACC_WIDTH:0]   lane_conv;
    logic [SUM_WIDTH-1:0] lane_sum;
    logic                 lane_sat;
    logic                 beat_sat;
    logic [ACC_WIDTH-1:0] beat_sum;
    logic [ACC_WIDTH:0]   acc_ext;
    logic [ACC_WIDTH-1:0] acc_total;
    logic                 sticky_total;
    logic                 stall;
    logic                 accept;

    // NOTE: every signal written in an always_comb gets a default at the top of the block,
    // otherwise a path that skips the assignment infers a latch.
    always_comb begin
        lane_conv = '0;
        lane_sum  = '0;
        lane_sat  = 1'b0;
        for (int i = 0; i < N_ROWS; i++) begin
            lane_conv = convert_lane(op_i[i*WIDTH +: WIDTH]);
            if (strb_i[i]) begin
                lane_sum = lane_sum + SUM_WIDTH'(lane_conv[ACC_WIDTH-1:0]);
                lane_sat = lane_sat | lane_conv[ACC_WIDTH];
            end
        end
        beat_sat = lane_sat || (lane_sum > SUM_WIDTH'(ACC_MAX));
        beat_sum = (lane_sum > SUM_WIDTH'(ACC_MAX)) ? ACC_MAX : lane_sum[ACC_WIDTH-1:0];
    end

    // A finished vector waiting in stage 1 cannot move while the output register is still held.
    assign stall   = s1_valid_q & s1_last_q & valid_q & ~ready_i;
    assign ready_o = enable_i & ~stall & ~clear_i;
    assign accept  = valid_i & ready_o;

    assign acc_ext      = {1'b0, acc_q} + {1'b0, s1_sum_q};
    assign acc_total    = acc_ext[ACC_WIDTH] ? ACC_MAX : acc_ext[ACC_WIDTH-1:0];
    assign sticky_total = sticky_q | s1_sat_q | acc_ext[ACC_WIDTH];

    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_last_d  = s1_last_q;
        s1_sat_d   = s1_sat_q;
        s1_sum_d   = s1_sum_q;
        acc_d      = acc_q;
        sticky_d   = sticky_q;
        sum_d      = sum_q;
        ovf_d      = ovf_q;
        valid_d    = valid_q;
        if (clear_i) begin
            s1_valid_d = 1'b0;
            s1_last_d  = 1'b0;
            s1_sat_d   = 1'b0;
            s1_sum_d   = '0;
            acc_d      = '0;
            sticky_d   = 1'b0;
            sum_d      = '0;
            ovf_d      = 1'b0;
            valid_d    = 1'b0;
        end else if (enable_i) begin
            if (valid_q && ready_i)
                valid_d = 1'b0;
            if (!stall) begin
                s1_valid_d = accept;
                if (accept) begin
                    s1_last_d = last_i;
                    s1_sat_d  = beat_sat;
                    s1_sum_d  = beat_sum;
                end
                if (s1_valid_q) begin
                    if (s1_last_q) begin
                        sum_d    = acc_total;
                        ovf_d    = sticky_total;
                        valid_d  = 1'b1;
                        acc_d    = '0;
                        sticky_d = 1'b0;
                    end else begin
                        acc_d    = acc_total;
                        sticky_d = sticky_total;
                    end
                end
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples the
    // pre-edge values of the others; blocking here would create order-dependent simulation.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            s1_valid_q <= 1'b0;
            s1_last_q  <= 1'b0;
            s1_sat_q   <= 1'b0;
            s1_sum_q   <= '0;
            acc_q      <= '0;
            sticky_q   <= 1'b0;
            sum_q      <= '0;
            ovf_q      <= 1'b0;
            valid_q    <= 1'b0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_last_q  <= s1_last_d;
            s1_sat_q   <= s1_sat_d;
            s1_sum_q   <= s1_sum_d;
            acc_q      <= acc_d;
            sticky_q   <= sticky_d;
            sum_q      <= sum_d;
            ovf_q      <= ovf_d;
            valid_q    <= valid_d;
        end
    end

    assign sum_o      = sum_q;
    assign overflow_o = ovf_q;
    assign valid_o    = valid_q;

endmodule

// File: tb/tb_expu_accumulator.sv
// Scoreboard bench for expu_accumulator: a real-arithmetic lane model predicts each vector
// result, a monitor pops predictions whenever the DUT hands a result downstream.

module tb_expu_accumulator;

    localparam int     N_ROWS    = 8;
    localparam int     WIDTH     = 16;
    localparam int     ACC_WIDTH = 32;
    localparam longint ACC_MAX   = 64'h0000_0000_FFFF_FFFF;

    typedef struct {
        longint sum;
        bit     ovf;
    } result_t;

    logic                    clk_i;
    logic                    rst_ni;
    logic                    clear_i;
    logic                    enable_i;
    logic                    valid_i;
    logic                    ready_o;
    logic [N_ROWS-1:0]       strb_i;
    logic [N_ROWS*WIDTH-1:0] op_i;
    logic                    last_i;
    logic [ACC_WIDTH-1:0]    sum_o;
    logic                    overflow_o;
    logic                    valid_o;
    logic                    ready_i;

    result_t exp_q[$];
    longint  part_total;
    bit      part_ovf;
    bit      rand_ready;
    int      errors;
    int      checks;

    bit                   hold_valid;
    logic [ACC_WIDTH-1:0] hold_sum;
    logic                 hold_ovf;

    expu_accumulator dut (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .clear_i    (clear_i),
        .enable_i   (enable_i),
        .valid_i    (valid_i),
        .ready_o    (ready_o),
        .strb_i     (strb_i),
        .op_i       (op_i),
        .last_i     (last_i),
        .sum_o      (sum_o),
        .overflow_o (overflow_o),
        .valid_o    (valid_o),
        .ready_i    (ready_i)
    );

    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        checks++;
        errors++;
        $display("FAIL %s: wait bound expired", name);
    endtask

    // Lane value from the float's meaning: (1 + m/128) * 2^(e-127), scaled by 2^16, floored.
    function automatic void lane_model(input logic [15:0] x, output longint v, output bit sat);
        int  e;
        int  m;
        real r;
        e   = int'(x[14:7]);
        m   = int'(x[6:0]);
        v   = 0;
        sat = 0;
        if (x[15] || e == 0) return;
        if (e == 255) begin
            v   = ACC_MAX;
            sat = 1;
            return;
        end
        r = (1.0 + m / 128.0) * (2.0 ** (e - 127));
        if (r >= 65536.0) begin
            v   = ACC_MAX;
            sat = 1;
        end else begin
            v = longint'($floor(r * 65536.0));
        end
    endfunction

    function automatic logic [N_ROWS*WIDTH-1:0] fill(input logic [15:0] x);
        return {N_ROWS{x}};
    endfunction

    function automatic logic [15:0] rand_op();
        int          sel;
        logic [15:0] x;
        sel      = $urandom_range(0, 31);
        x[15]    = 1'b0;
        x[6:0]   = 7'($urandom);
        x[14:7]  = 8'($urandom_range(100, 134));
        case (sel)
            0: x[15]   = 1'b1;
            1: x[14:7] = 8'd0;
            2: x[14:7] = 8'd255;
            3: x[14:7] = 8'($urandom_range(138, 145));
            default: ;
        endcase
        return x;
    endfunction

    // Called at posedge+1; returns at posedge+1 just after the accepting edge.
    task automatic send_beat(input logic [N_ROWS-1:0] strb, input logic [N_ROWS*WIDTH-1:0] ops,
                             input bit last, input bit directed, input longint dsum, input bit dovf);
        int      n;
        longint  v;
        bit      sat;
        result_t r;
        valid_i = 1'b1;
        strb_i  = strb;
        op_i    = ops;
        last_i  = last;
        n       = 0;
        forever begin
            @(negedge clk_i);
            if (ready_o) break;
            n++;
            if (n > 200) begin
                timeout("ready_wait");
                valid_i = 1'b0;
                return;
            end
        end
        @(posedge clk_i);
        #1;
        valid_i = 1'b0;
        for (int i = 0; i < N_ROWS; i++) begin
            if (strb[i]) begin
                lane_model(ops[i*WIDTH +: WIDTH], v, sat);
                part_total += v;
                part_ovf   |= sat;
            end
        end
        if (last) begin
            r.sum = directed ? dsum : ((part_total > ACC_MAX) ? ACC_MAX : part_total);
            r.ovf = directed ? dovf : (part_ovf || part_total > ACC_MAX);
            exp_q.push_back(r);
            part_total = 0;
            part_ovf   = 0;
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk_i);
        #1;
    endtask

    task automatic wait_valid();
        int n;
        n = 0;
        while (!valid_o && n < 50) begin
            @(negedge clk_i);
            n++;
        end
        if (!valid_o) timeout("valid_wait");
        @(posedge clk_i);
        #1;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || valid_o) && n < 3000) begin
            @(negedge clk_i);
            n++;
        end
        if (n >= 3000) timeout("drain");
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        forever begin
            @(posedge clk_i);
            #2;
            if (rand_ready) ready_i = ($urandom_range(0, 3) != 0);
        end
    end

    // Monitor: a result transfers at the next edge when valid_o & ready_i & enable_i.
    initial begin
        result_t r;
        hold_valid = 0;
        forever begin
            @(negedge clk_i);
            if (!rst_ni || clear_i) begin
                hold_valid = 0;
            end else begin
                if (hold_valid) begin
                    check("hold_valid", valid_o, 1);
                    check("hold_sum", sum_o, hold_sum);
                    check("hold_ovf", overflow_o, hold_ovf);
                end
                hold_valid = 0;
                if (valid_o) begin
                    if (ready_i && enable_i) begin
                        if (exp_q.size() == 0) begin
                            checks++;
                            errors++;
                            $display("FAIL unexpected_result: sum_o=0x%0h with no vector outstanding", sum_o);
                        end else begin
                            r = exp_q.pop_front();
                            check("sum", sum_o, r.sum);
                            check("overflow", overflow_o, r.ovf);
                        end
                    end else begin
                        hold_valid = 1;
                        hold_sum   = sum_o;
                        hold_ovf   = overflow_o;
                    end
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        errors     = 0;
        checks     = 0;
        rst_ni     = 1'b0;
        clear_i    = 1'b0;
        enable_i   = 1'b1;
        valid_i    = 1'b0;
        strb_i     = '0;
        op_i       = '0;
        last_i     = 1'b0;
        ready_i    = 1'b1;
        rand_ready = 0;
        part_total = 0;
        part_ovf   = 0;

        idle(3);
        check("reset_valid", valid_o, 0);
        check("reset_sum", sum_o, 0);
        check("reset_ovf", overflow_o, 0);
        rst_ni = 1'b1;
        idle(1);
        check("reset_ready", ready_o, 1);

        // Conversion and summation corner cases with hand-derived results.
        send_beat(8'hFF, fill(16'h3F80), 1, 1, 64'h0008_0000, 0);
        send_beat(8'h55, fill(16'h3F80), 1, 1, 64'h0004_0000, 0);
        send_beat(8'hFF, fill(16'hBF80), 1, 1, 64'h0000_0000, 0);
        send_beat(8'h01, fill(16'h3B80), 1, 1, 64'h0000_0100, 0);
        send_beat(8'hFF, fill(16'h0040), 1, 1, 64'h0000_0000, 0);
        send_beat(8'hFF, fill(16'h4000), 0, 1, 0, 0);
        send_beat(8'hFF, fill(16'h4000), 0, 1, 0, 0);
        send_beat(8'hFF, fill(16'h4000), 1, 1, 64'h0030_0000, 0);
        send_beat(8'h01, fill(16'h4780), 1, 1, 64'hFFFF_FFFF, 1);
        send_beat(8'hFF, fill(16'h3F80), 1, 1, 64'h0008_0000, 0);
        send_beat(8'h01, fill(16'h477F), 1, 1, 64'hFF00_0000, 0);
        send_beat(8'hFF, fill(16'h477F), 1, 1, 64'hFFFF_FFFF, 1);
        send_beat(8'h01, fill(16'h477F), 0, 1, 0, 0);
        send_beat(8'h01, fill(16'h477F), 1, 1, 64'hFFFF_FFFF, 1);
        send_beat(8'h02, fill(16'h7F80), 1, 1, 64'hFFFF_FFFF, 1);
        send_beat(8'hFF, fill(16'h3F80), 1, 1, 64'h0008_0000, 0);
        drain();

        // Backpressure: result held at output, next finished vector parked in stage 1.
        ready_i = 1'b0;
        send_beat(8'hFF, fill(16'h3F80), 1, 1, 64'h0008_0000, 0);
        send_beat(8'hFF, fill(16'h4000), 1, 1, 64'h0010_0000, 0);
        valid_i = 1'b1;
        strb_i  = 8'hFF;
        op_i    = fill(16'h4780);
        last_i  = 1'b1;
        @(negedge clk_i);
        check("bp_ready", ready_o, 0);
        check("bp_valid", valid_o, 1);
        check("bp_sum", sum_o, 64'h0008_0000);
        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        check("bp_ready_late", ready_o, 0);
        check("bp_sum_late", sum_o, 64'h0008_0000);
        @(posedge clk_i);
        #1;
        valid_i = 1'b0;
        ready_i = 1'b1;
        drain();

        // Global enable low freezes the pending result even with ready_i high.
        ready_i = 1'b0;
        send_beat(8'hFF, fill(16'h3F80), 1, 1, 64'h0008_0000, 0);
        wait_valid();
        enable_i = 1'b0;
        ready_i  = 1'b1;
        @(negedge clk_i);
        check("en_ready", ready_o, 0);
        check("en_valid", valid_o, 1);
        repeat (3) @(posedge clk_i);
        @(negedge clk_i);
        check("en_hold_valid", valid_o, 1);
        check("en_hold_sum", sum_o, 64'h0008_0000);
        @(posedge clk_i);
        #1;
        enable_i = 1'b1;
        drain();

        // Clear mid-vector with a result pending: both are discarded.
        ready_i = 1'b0;
        send_beat(8'hFF, fill(16'h3F80), 1, 1, 64'h0008_0000, 0);
        send_beat(8'hFF, fill(16'h4000), 0, 0, 0, 0);
        send_beat(8'hFF, fill(16'h4000), 0, 0, 0, 0);
        wait_valid();
        clear_i = 1'b1;
        @(negedge clk_i);
        check("clr_ready", ready_o, 0);
        @(posedge clk_i);
        #1;
        clear_i = 1'b0;
        exp_q.delete();
        part_total = 0;
        part_ovf   = 0;
        check("clr_valid", valid_o, 0);
        check("clr_sum", sum_o, 0);
        ready_i = 1'b1;
        send_beat(8'hFF, fill(16'h3F80), 1, 1, 64'h0008_0000, 0);
        drain();

        // Asynchronous reset mid-vector with a result pending.
        ready_i = 1'b0;
        send_beat(8'hFF, fill(16'h4000), 1, 1, 64'h0010_0000, 0);
        send_beat(8'hFF, fill(16'h4000), 0, 0, 0, 0);
        wait_valid();
        rst_ni = 1'b0;
        #1;
        check("rst_valid", valid_o, 0);
        check("rst_sum", sum_o, 0);
        check("rst_ovf", overflow_o, 0);
        exp_q.delete();
        part_total = 0;
        part_ovf   = 0;
        idle(2);
        rst_ni  = 1'b1;
        ready_i = 1'b1;
        idle(1);
        send_beat(8'hFF, fill(16'h3F80), 1, 1, 64'h0008_0000, 0);
        drain();

        // Randomized traffic with random downstream backpressure, checked by the model.
        rand_ready = 1;
        for (int i = 0; i < 300; i++) begin
            logic [N_ROWS*WIDTH-1:0] ops;
            idle($urandom_range(0, 2));
            for (int l = 0; l < N_ROWS; l++) ops[l*WIDTH +: WIDTH] = rand_op();
            send_beat(N_ROWS'($urandom), ops, ($urandom_range(0, 2) == 0), 0, 0, 0);
        end
        send_beat(8'hFF, fill(16'h3F80), 1, 0, 0, 0);
        // Back-to-back single-beat vectors at full rate.
        rand_ready = 0;
        ready_i    = 1'b1;
        for (int i = 0; i < 20; i++) begin
            logic [N_ROWS*WIDTH-1:0] ops;
            for (int l = 0; l < N_ROWS; l++) ops[l*WIDTH +: WIDTH] = rand_op();
            send_beat(N_ROWS'($urandom), ops, 1, 0, 0, 0);
        end
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
